// File: rtl/interface_hcsr04_bcd_if.sv
// Bus between the control unit and the HC-SR04 measurement stage.
// The master side starts measurements and drives the raw echo pin; the slave side is the measurement block.
interface interface_hcsr04_bcd_if;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  modport master (
    output medir,
    output echo,
    input  trigger,
    input  medida,
    input  pronto,
    input  timeout,
    input  db_estado
  );

  modport slave (
    input  medir,
    input  echo,
    output trigger,
    output medida,
    output pronto,
    output timeout,
    output db_estado
  );
endinterface

// File: rtl/interface_hcsr04_bcd.sv
// HC-SR04 front end: fires the trigger, times the echo and returns a 3-digit BCD distance in cm.
// Defining HCSR04_ROUND_EN rounds the result to the nearest cm; without it the result is truncated.
module interface_hcsr04_bcd #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input logic                   clock,
  input logic                   reset,
  interface_hcsr04_bcd_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

`ifdef HCSR04_ROUND_EN
  localparam logic [PW-1:0] PRESC_PRELOAD = PW'(CYCLES_PER_CM / 2);
`else
  localparam logic [PW-1:0] PRESC_PRELOAD = '0;
`endif

  typedef enum logic [3:0] {
    S_INICIAL       = 4'd0,
    S_PREPARACAO    = 4'd1,
    S_ENVIA_TRIGGER = 4'd2,
    S_ESPERA_ECHO   = 4'd3,
    S_MEDIDA        = 4'd4,
    S_ARMAZENAMENTO = 4'd5,
    S_ESTOURO       = 4'd6,
    S_FINAL_MEDIDA  = 4'd7
  } state_t;

  state_t          state_q, state_d;
  logic            echo_meta_q, echo_meta_d;
  logic            echo_s_q, echo_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            trigger_q, trigger_d;
  logic [11:0]     medida_q, medida_d;
  logic            pronto_q, pronto_d;
  logic            timeout_q, timeout_d;

  logic            presc_wrap;
  logic [PW-1:0]   presc_next;
  logic [11:0]     bcd_inc;

  assign presc_wrap = (presc_q == PW'(CYCLES_PER_CM - 1));
  assign presc_next = presc_wrap ? '0 : presc_q + PW'(1);

  // Three cascaded decimal digits that stick at 999 instead of rolling over.
  always_comb begin
    bcd_inc = bcd_q;
    if (bcd_q != 12'h999) begin
      if (bcd_q[3:0] != 4'd9) begin
        bcd_inc[3:0] = bcd_q[3:0] + 4'd1;
      end else begin
        bcd_inc[3:0] = 4'd0;
        if (bcd_q[7:4] != 4'd9) begin
          bcd_inc[7:4] = bcd_q[7:4] + 4'd1;
        end else begin
          bcd_inc[7:4]  = 4'd0;
          bcd_inc[11:8] = bcd_q[11:8] + 4'd1;
        end
      end
    end
  end

  // The first echo_s high cycle is seen in espera_echo, so it is counted there as well.
  always_comb begin
    state_d     = state_q;
    echo_meta_d = bus.echo;
    echo_s_d    = echo_meta_q;
    cnt_d       = cnt_q;
    presc_d     = presc_q;
    bcd_d       = bcd_q;
    medida_d    = medida_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_INICIAL: begin
        if (bus.medir) state_d = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        cnt_d     = '0;
        presc_d   = PRESC_PRELOAD;
        bcd_d     = 12'h000;
        timeout_d = 1'b0;
        state_d   = S_ENVIA_TRIGGER;
      end
      S_ENVIA_TRIGGER: begin
        if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_ESPERA_ECHO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ESPERA_ECHO: begin
        if (echo_s_q) begin
          presc_d = presc_next;
          if (presc_wrap) bcd_d = bcd_inc;
          cnt_d   = CW'(1);
          state_d = S_MEDIDA;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          state_d = S_ESTOURO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEDIDA: begin
        if (!echo_s_q) begin
          state_d = S_ARMAZENAMENTO;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          state_d = S_ESTOURO;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          presc_d = presc_next;
          if (presc_wrap) bcd_d = bcd_inc;
        end
      end
      S_ARMAZENAMENTO: begin
        medida_d = bcd_q;
        state_d  = S_FINAL_MEDIDA;
      end
      S_ESTOURO: begin
        medida_d  = 12'h999;
        timeout_d = 1'b1;
        state_d   = S_FINAL_MEDIDA;
      end
      S_FINAL_MEDIDA: begin
        state_d = S_INICIAL;
      end
      default: begin
        state_d = S_INICIAL;
      end
    endcase

    trigger_d = (state_d == S_ENVIA_TRIGGER);
    pronto_d  = (state_d == S_FINAL_MEDIDA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INICIAL;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      cnt_q       <= '0;
      presc_q     <= '0;
      bcd_q       <= 12'h000;
      trigger_q   <= 1'b0;
      medida_q    <= 12'h000;
      pronto_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      echo_meta_q <= echo_meta_d;
      echo_s_q    <= echo_s_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      bcd_q       <= bcd_d;
      trigger_q   <= trigger_d;
      medida_q    <= medida_d;
      pronto_q    <= pronto_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.trigger   = trigger_q;
  assign bus.medida    = medida_q;
  assign bus.pronto    = pronto_q;
  assign bus.timeout   = timeout_q;
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_bcd.sv
// Bench for interface_hcsr04_bcd with scaled-down timing; tracks expected trigger/pronto/medida/timeout per cycle.
// Honours HCSR04_ROUND_EN the same way as the design.
module tb_interface_hcsr04_bcd;

  localparam int TRIG = 20;
  localparam int CPC  = 4;
  localparam int TMO  = 8000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  interface_hcsr04_bcd_if bus_if ();

  interface_hcsr04_bcd #(
    .TRIG_CYCLES   (TRIG),
    .CYCLES_PER_CM (CPC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  // cyc holds the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          trig_lo   = -1;
  int          trig_hi   = -2;
  int          pronto_at = -1;
  int          clear_at  = -1;
  logic [11:0] m_medida  = 12'h000;
  logic        m_timeout = 1'b0;
  logic [11:0] next_medida  = 12'h000;
  logic        next_timeout = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] expectedBcd(input int w);
    int cm;
`ifdef HCSR04_ROUND_EN
    cm = (w + CPC / 2) / CPC;
`else
    cm = w / CPC;
`endif
    if (cm > 999) cm = 999;
    return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
  endfunction

  // Per-cycle comparison against the timeline the stimulus task has predicted.
  always @(negedge clock) begin
    if (!reset) begin
      if (cyc == clear_at) m_timeout = 1'b0;
      if (cyc == pronto_at) begin
        m_medida  = next_medida;
        m_timeout = next_timeout;
      end
      checkOutput("trigger", 32'(bus_if.trigger), 32'(cyc >= trig_lo && cyc <= trig_hi));
      checkOutput("pronto",  32'(bus_if.pronto),  32'(cyc == pronto_at));
      checkOutput("medida",  32'(bus_if.medida),  32'(m_medida));
      checkOutput("timeout", 32'(bus_if.timeout), 32'(m_timeout));
    end
  end

  // One measurement: width 0 means the echo never rises. Returns at the negedge where pronto is expected.
  task automatic applyStimulus(input int width, input int gap, input bit extra_medir);
    int a;
    int e0;
    @(negedge clock);
    bus_if.medir = 1'b1;
    a        = cyc + 1;
    trig_lo  = a + 1;
    trig_hi  = a + TRIG;
    clear_at = a + 1;
    e0       = a + TRIG + 1;
    if (width == 0) begin
      next_medida  = 12'h999;
      next_timeout = 1'b1;
      pronto_at    = e0 + TMO + 2;
    end else begin
      next_medida  = expectedBcd(width);
      next_timeout = 1'b0;
    end
    @(negedge clock);
    bus_if.medir = 1'b0;
    checkOutput("db_estado_prep", 32'(bus_if.db_estado), 32'd1);
    while (cyc < a + 5) @(negedge clock);
    checkOutput("db_estado_trig", 32'(bus_if.db_estado), 32'd2);
    if (extra_medir) begin
      bus_if.medir = 1'b1;
      @(negedge clock);
      bus_if.medir = 1'b0;
    end
    if (width > 0) begin
      while (cyc < e0 + gap) @(negedge clock);
      bus_if.echo = 1'b1;
      for (int i = 0; i < width; i++) begin
        bus_if.medir = (extra_medir && i == width / 2);
        @(negedge clock);
      end
      bus_if.medir = 1'b0;
      bus_if.echo  = 1'b0;
      pronto_at    = cyc + 4;
    end
    while (cyc < pronto_at) @(negedge clock);
  endtask

  initial begin
    bus_if.medir = 1'b0;
    bus_if.echo  = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_trigger", 32'(bus_if.trigger),   32'd0);
    checkOutput("reset_medida",  32'(bus_if.medida),    32'h000);
    checkOutput("reset_pronto",  32'(bus_if.pronto),    32'd0);
    checkOutput("reset_timeout", 32'(bus_if.timeout),   32'd0);
    checkOutput("reset_estado",  32'(bus_if.db_estado), 32'd0);
    #2 reset = 1'b0;

    applyStimulus(40, 50, 1'b0);
    checkOutput("w40_medida",  32'(bus_if.medida),  32'h010);
    checkOutput("w40_timeout", 32'(bus_if.timeout), 32'd0);

    applyStimulus(7, 3, 1'b0);
`ifdef HCSR04_ROUND_EN
    checkOutput("w7_medida", 32'(bus_if.medida), 32'h002);
`else
    checkOutput("w7_medida", 32'(bus_if.medida), 32'h001);
`endif

    applyStimulus(39, 0, 1'b0);
`ifdef HCSR04_ROUND_EN
    checkOutput("w39_medida", 32'(bus_if.medida), 32'h010);
`else
    checkOutput("w39_medida", 32'(bus_if.medida), 32'h009);
`endif

    applyStimulus(4400, 10, 1'b0);
    checkOutput("w4400_medida",  32'(bus_if.medida),  32'h999);
    checkOutput("w4400_timeout", 32'(bus_if.timeout), 32'd0);

    applyStimulus(396, 5, 1'b0);
    checkOutput("w396_medida", 32'(bus_if.medida), 32'h099);

    applyStimulus(400, 5, 1'b1);
    checkOutput("w400_medida", 32'(bus_if.medida), 32'h100);

    applyStimulus(0, 0, 1'b0);
    checkOutput("noecho_medida",  32'(bus_if.medida),  32'h999);
    checkOutput("noecho_timeout", 32'(bus_if.timeout), 32'd1);

    applyStimulus(8, 2, 1'b0);
    checkOutput("after_to_timeout", 32'(bus_if.timeout), 32'd0);
    checkOutput("after_to_medida",  32'(bus_if.medida),  32'h002);

    // Abort a measurement halfway through the trigger pulse.
    @(negedge clock);
    @(negedge clock);
    bus_if.medir = 1'b1;
    trig_lo  = cyc + 2;
    trig_hi  = cyc + 1 + TRIG;
    clear_at = cyc + 2;
    @(negedge clock);
    bus_if.medir = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_trigger", 32'(bus_if.trigger), 32'd0);
    checkOutput("abort_medida",  32'(bus_if.medida),  32'h000);
    checkOutput("abort_pronto",  32'(bus_if.pronto),  32'd0);
    trig_lo   = -1;
    trig_hi   = -2;
    pronto_at = -1;
    clear_at  = -1;
    m_medida  = 12'h000;
    m_timeout = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (40) @(negedge clock);

    for (int n = 0; n < 15; n++) begin
      applyStimulus(int'($urandom_range(1, 1200)), int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
